gol_sim_sequencer: RTL

Control sequencer for the Game-of-Life simulation engines. It owns the top-level phase FSM: boot-time randomize, then periodic vsync-aligned UPDATE→COPY generations, plus optional single-stepping. It issues one-cycle start pulses to the INIT, UPDATE and COPY engines and waits for their done pulses. It sits between the ui_in control pins, the hvsync generator and the board-state engines inside the VGA Game-of-Life top level.

---
 rtl/gol_sim_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gol_sim_sequencer.sv
// rtl/gol_sim_sequencer.sv - Game-of-Life phase sequencer: boot INIT, vsync-aligned UPDATE/COPY, watchdog.
// Optional single-step support is compiled in with GOL_STEP_EN.
module gol_sim_sequencer #(
    parameter int UPDATE_INTERVAL = 2400000,
    parameter int TIMEOUT         = 4096,
    parameter bit VSYNC_ACTIVE    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        randomize,
    input  logic        step,
    input  logic        vsync,
    input  logic        init_done,
    input  logic        update_done,
    input  logic        copy_done,
    output logic        init_start,
    output logic        update_start,
    output logic        copy_start,
    output logic [1:0]  phase,
    output logic        busy,
    output logic [15:0] generation,
    output logic        timeout_err
);
    localparam int TW = $clog2(UPDATE_INTERVAL + 1);
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(UPDATE_INTERVAL);
    localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_COPY   = 2'd2,
        S_INIT   = 2'd3
    } state_t;

    state_t        state, state_next;
    logic          boot_pending, step_pending, vs_prev, vs_edge;
    logic [TW-1:0] timer;
    logic [WW-1:0] wd;
    logic          launch_boot, launch_step, launch_timer, phase_done, wd_expire;

    assign vs_edge = (vsync == VSYNC_ACTIVE) && (vs_prev != VSYNC_ACTIVE);
    assign phase   = state;
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_next   = state;
        launch_boot  = 1'b0;
        launch_step  = 1'b0;
        launch_timer = 1'b0;
        phase_done   = 1'b0;
        wd_expire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (boot_pending) begin
                    launch_boot = 1'b1;
                    state_next  = S_INIT;
                end else if (step_pending && vs_edge) begin
                    launch_step = 1'b1;
                    state_next  = S_UPDATE;
                end else if (run && (timer == TIMER_MAX) && vs_edge) begin
                    launch_timer = 1'b1;
                    state_next   = randomize ? S_INIT : S_UPDATE;
                end
            end
            S_INIT:   phase_done = init_done;
            S_UPDATE: phase_done = update_done;
            S_COPY:   phase_done = copy_done;
            default:  ;
        endcase
        // A done pulse in the expiry cycle takes precedence over the watchdog.
        if (state != S_IDLE) begin
            if (phase_done) begin
                state_next = (state == S_UPDATE) ? S_COPY : S_IDLE;
            end else if (wd == WD_MAX) begin
                wd_expire  = 1'b1;
                state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            boot_pending <= 1'b1;
            timer        <= '0;
            wd           <= '0;
            generation   <= '0;
            timeout_err  <= 1'b0;
            init_start   <= 1'b0;
            update_start <= 1'b0;
            copy_start   <= 1'b0;
            vs_prev      <= !VSYNC_ACTIVE;
        end else begin
            state   <= state_next;
            vs_prev <= vsync;
            if (launch_boot)
                boot_pending <= 1'b0;
            // Step launches leave the timer alone so a saturated timer still fires on the next edge.
            if (state == S_IDLE) begin
                if (launch_boot || launch_timer)
                    timer <= '0;
                else if (run && !launch_step && (timer != TIMER_MAX))
                    timer <= timer + TW'(1);
            end
            if ((state == S_IDLE) || (state_next != state))
                wd <= '0;
            else
                wd <= wd + WW'(1);
            init_start   <= (state_next == S_INIT)   && (state != S_INIT);
            update_start <= (state_next == S_UPDATE) && (state != S_UPDATE);
            copy_start   <= (state_next == S_COPY)   && (state != S_COPY);
            if ((state == S_INIT) && phase_done)
                generation <= '0;
            else if ((state == S_COPY) && phase_done)
                generation <= generation + 16'd1;
            if (wd_expire)
                timeout_err <= 1'b1;
        end
    end

`ifdef GOL_STEP_EN
    logic step_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_prev    <= 1'b0;
            step_pending <= 1'b0;
        end else begin
            step_prev    <= step;
            step_pending <= (step_pending && !launch_step) || (step && !step_prev && !run);
        end
    end
`else
    logic unused_step;

    assign step_pending = 1'b0;
    assign unused_step  = step ^ launch_step;
`endif

endmodule
